fft_out_reorder: RTL and testbench

//  Consumer of the R2SDF butterfly-stage output stream. Last bf_stage (n=N) emits a 2^N-point

---
 rtl/fft_out_reorder.sv | 202 ++++++++++++++++++++
 tb/tb_fft_out_reorder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_reorder.sv
// ---------------------------------------------------------------------------
// fft_out_reorder
//
// Sits after the final R2SDF butterfly stage. That stage emits each 2^N-point
// frame in bit-reversed index order, marked by a one-clock start pulse. This
// block writes each frame into one half of a ping-pong RAM at bit-reversed
// addresses and replays it in natural order. Each replayed frame carries its
// own start pulse.
//
// Ports
//   clk        in   rising-edge clock for all state
//   reset      in   asynchronous, active-low reset (0 = reset)
//   ip         in   input sample, ip[1] = real, ip[0] = imag
//   start_ip   in   one-clock pulse: ip in this cycle is sample 0 of a frame
//   op         out  reordered sample, op[1] = real, op[0] = imag
//   op_valid   out  op carries a valid sample this cycle
//   start_op   out  one-clock pulse coincident with X[0] of a frame
//   frame_err  out  sticky: a frame was aborted by an early start_ip
// ---------------------------------------------------------------------------
module fft_out_reorder #(
    parameter int N = 3,            // log2 of frame length
    parameter int W = 32            // bits per real/imag component
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0][W-1:0]   ip,
    input  logic                start_ip,
    output logic [1:0][W-1:0]   op,
    output logic                op_valid,
    output logic                start_op,
    output logic                frame_err
);

    localparam int L = 1 << N;
    localparam logic [N-1:0] LAST = N'(L - 1);

    typedef enum logic { W_IDLE, W_FILL  } w_state_t;
    typedef enum logic { R_IDLE, R_DRAIN } r_state_t;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    w_state_t       w_state_q, w_state_d;
    logic [N-1:0]   wcnt_q, wcnt_d;
    logic           wr_bank_q, wr_bank_d;
    logic           handoff_q, handoff_d;       // one-clock "bank is full" strobe
    logic           hand_bank_q, hand_bank_d;   // which bank the strobe refers to
    logic           frame_err_q, frame_err_d;

    logic           we;
    logic [N-1:0]   waddr;
    logic [N-1:0]   wcnt_rev;

    // Bit-reversed write address: sample k lands at address bitrev(k).
    // Reading addresses 0..L-1 in order then yields X[0..L-1].
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bitrev
            assign wcnt_rev[gi] = wcnt_q[N-1-gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state_q   <= W_IDLE;
            wcnt_q      <= '0;
            wr_bank_q   <= 1'b0;
            handoff_q   <= 1'b0;
            hand_bank_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            wcnt_q      <= wcnt_d;
            wr_bank_q   <= wr_bank_d;
            handoff_q   <= handoff_d;
            hand_bank_q <= hand_bank_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        w_state_d   = w_state_q;
        wcnt_d      = wcnt_q;
        wr_bank_d   = wr_bank_q;
        handoff_d   = 1'b0;
        hand_bank_d = hand_bank_q;
        frame_err_d = frame_err_q;
        we          = 1'b0;
        waddr       = wcnt_rev;

        case (w_state_q)
            W_IDLE: begin
                if (start_ip) begin
                    we        = 1'b1;
                    waddr     = '0;
                    wcnt_d    = N'(1);
                    w_state_d = W_FILL;
                end
            end
            W_FILL: begin
                we = 1'b1;
                if (start_ip) begin
                    // Early start: abandon the partial frame and restart in
                    // the same bank. The aborted data is simply overwritten.
                    frame_err_d = 1'b1;
                    waddr       = '0;
                    wcnt_d      = N'(1);
                end else if (wcnt_q == LAST) begin
                    handoff_d   = 1'b1;
                    hand_bank_d = wr_bank_q;
                    wr_bank_d   = ~wr_bank_q;
                    wcnt_d      = '0;
                    w_state_d   = W_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Ping-pong storage: {bank, addr} -> {real, imag}. The contents are
    // deliberately not cleared by reset. Writes are held off while reset is
    // asserted so that a start_ip seen during reset cannot touch the RAM.
    // ------------------------------------------------------------------
    logic [1:0][W-1:0] mem [0:2*L-1];

    always_ff @(posedge clk) begin
        if (we && reset) begin
            mem[{wr_bank_q, waddr}] <= ip;
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    r_state_t           r_state_q, r_state_d;
    logic [N-1:0]       rcnt_q, rcnt_d;
    logic               rd_bank_q, rd_bank_d;
    logic               op_valid_q, op_valid_d;
    logic               start_op_q, start_op_d;
    logic               rd_en;
    logic [1:0][W-1:0]  op_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q  <= R_IDLE;
            rcnt_q     <= '0;
            rd_bank_q  <= 1'b0;
            op_valid_q <= 1'b0;
            start_op_q <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            rcnt_q     <= rcnt_d;
            rd_bank_q  <= rd_bank_d;
            op_valid_q <= op_valid_d;
            start_op_q <= start_op_d;
        end
    end

    always_comb begin
        r_state_d  = r_state_q;
        rcnt_d     = rcnt_q;
        rd_bank_d  = rd_bank_q;
        op_valid_d = 1'b0;
        start_op_d = 1'b0;
        rd_en      = 1'b0;

        if (r_state_q == R_DRAIN) begin
            rd_en      = 1'b1;
            op_valid_d = 1'b1;
            start_op_d = (rcnt_q == '0);
            rcnt_d     = rcnt_q + 1'b1;
            if (rcnt_q == LAST) begin
                r_state_d = R_IDLE;
            end
        end

        // A handoff lands on the last drain cycle of the previous frame when
        // frames are back to back. Restarting here keeps the output gapless.
        if (handoff_q) begin
            rd_bank_d = hand_bank_q;
            rcnt_d    = '0;
            r_state_d = R_DRAIN;
        end
    end

    // Registered RAM read. op keeps its last value while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q <= '0;
        end else if (rd_en) begin
            op_q <= mem[{rd_bank_q, rcnt_q}];
        end
    end

    assign op        = op_q;
    assign op_valid  = op_valid_q;
    assign start_op  = start_op_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
module tb_fft_out_reorder;

    localparam int N    = 3;
    localparam int L    = 1 << N;
    localparam int W    = 32;
    localparam int MAXC = 4096;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0][W-1:0]   ip;
    logic                start_ip;
    logic [1:0][W-1:0]   op;
    logic                op_valid;
    logic                start_op;
    logic                frame_err;

    fft_out_reorder #(.N(N), .W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .ip       (ip),
        .start_ip (start_ip),
        .op       (op),
        .op_valid (op_valid),
        .start_op (start_op),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Cycle number = count of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed outputs per cycle (sampled on the falling edge).
    bit           lv [0:MAXC-1];
    bit           ls [0:MAXC-1];
    logic [W-1:0] lre[0:MAXC-1];
    logic [W-1:0] lim[0:MAXC-1];
    // Expected outputs per cycle from the reference model.
    bit           ev [0:MAXC-1];
    bit           es [0:MAXC-1];
    logic [W-1:0] ere[0:MAXC-1];
    logic [W-1:0] eim[0:MAXC-1];

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            lv[cyc]  <= op_valid;
            ls[cyc]  <= start_op;
            lre[cyc] <= op[1];
            lim[cyc] <= op[0];
        end
    end

    int checks = 0;
    int passed = 0;

    logic [W-1:0] fr_re[0:L-1];
    logic [W-1:0] fr_im[0:L-1];

    // Reverse the N low bits of k arithmetically.
    function automatic int brev(input int k);
        int r;
        r = 0;
        for (int b = 0; b < N; b++) r = (r * 2) + ((k >> b) & 1);
        return r;
    endfunction

    task automatic drive(input bit st, input logic [W-1:0] re, input logic [W-1:0] im);
        start_ip = st;
        ip[1]    = re;
        ip[0]    = im;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, $urandom);
    endtask

    task automatic rand_frame();
        for (int k = 0; k < L; k++) begin
            fr_re[k] = $urandom;
            fr_im[k] = $urandom;
        end
    endtask

    // Drive nsamp samples of fr_* starting with a start pulse. A complete
    // frame sampled from edge e0 must reappear as X[j] = sample bitrev(j)
    // after edge e0+L+1+j.
    task automatic send_frame(input int nsamp, input bit full);
        int e0;
        e0 = cyc + 1;
        for (int k = 0; k < nsamp; k++) drive(k == 0, fr_re[k], fr_im[k]);
        if (full) begin
            for (int j = 0; j < L; j++) begin
                ev[e0+L+1+j]  = 1'b1;
                es[e0+L+1+j]  = (j == 0);
                ere[e0+L+1+j] = fr_re[brev(j)];
                eim[e0+L+1+j] = fr_im[brev(j)];
            end
        end
    endtask

    task automatic test_reset();
        int c0;
        reset = 1'b0;
        start_ip = 1'b1;
        ip = '1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (op_valid !== 1'b0) $display("FAIL reset_op_valid got %b want 0", op_valid); else passed++;
        checks++; if (start_op !== 1'b0) $display("FAIL reset_start_op got %b want 0", start_op); else passed++;
        checks++; if (op !== '0) $display("FAIL reset_op got %h want 0", op); else passed++;
        checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err); else passed++;
        reset = 1'b1;
        c0 = cyc + 1;
        idle(L + 6);
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (lv[c] !== 1'b0 || ls[c] !== 1'b0)
                $display("FAIL reset_idle cyc=%0d got v=%0b s=%0b want v=0 s=0", c, lv[c], ls[c]);
            else passed++;
        end
    endtask

    task automatic test_single_frame();
        int c0;
        logic [W-1:0] xr, xi;
        for (int k = 0; k < L; k++) begin
            fr_re[k] = W'(brev(k) << 16);
            fr_im[k] = -fr_re[k];
        end
        c0 = cyc + 1;
        send_frame(L, 1'b1);
        idle(L + 4);
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (lv[c] !== ev[c] || ls[c] !== es[c] || (ev[c] && (lre[c] !== ere[c] || lim[c] !== eim[c])))
                $display("FAIL single_frame cyc=%0d got v=%0b s=%0b op=%h_%h want v=%0b s=%0b op=%h_%h",
                         c, lv[c], ls[c], lre[c], lim[c], ev[c], es[c], ere[c], eim[c]);
            else passed++;
        end
        for (int j = 0; j < L; j++) begin
            xr = W'(j << 16);
            xi = -xr;
            checks++;
            if (lv[c0+L+1+j] !== 1'b1 || lre[c0+L+1+j] !== xr || lim[c0+L+1+j] !== xi)
                $display("FAIL single_natural X%0d got v=%0b %h_%h want v=1 %h_%h",
                         j, lv[c0+L+1+j], lre[c0+L+1+j], lim[c0+L+1+j], xr, xi);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = cyc + 1;
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            send_frame(L, 1'b1);
        end
        idle(L + 4);
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (lv[c] !== ev[c] || ls[c] !== es[c] || (ev[c] && (lre[c] !== ere[c] || lim[c] !== eim[c])))
                $display("FAIL back_to_back cyc=%0d got v=%0b s=%0b op=%h_%h want v=%0b s=%0b op=%h_%h",
                         c, lv[c], ls[c], lre[c], lim[c], ev[c], es[c], ere[c], eim[c]);
            else passed++;
        end
        checks++; if (frame_err !== 1'b0) $display("FAIL b2b_frame_err got %b want 0", frame_err); else passed++;
    endtask

    task automatic test_abort();
        int c0;
        c0 = cyc + 1;
        rand_frame();
        send_frame(4, 1'b0);
        rand_frame();
        send_frame(L, 1'b1);
        idle(L + 4);
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (lv[c] !== ev[c] || ls[c] !== es[c] || (ev[c] && (lre[c] !== ere[c] || lim[c] !== eim[c])))
                $display("FAIL abort cyc=%0d got v=%0b s=%0b op=%h_%h want v=%0b s=%0b op=%h_%h",
                         c, lv[c], ls[c], lre[c], lim[c], ev[c], es[c], ere[c], eim[c]);
            else passed++;
        end
        checks++; if (frame_err !== 1'b1) $display("FAIL abort_frame_err got %b want 1", frame_err); else passed++;
        idle(5);
        checks++; if (frame_err !== 1'b1) $display("FAIL abort_sticky got %b want 1", frame_err); else passed++;
    endtask

    task automatic test_reset_readout();
        int c0;
        checks++; if (frame_err !== 1'b1) $display("FAIL pre_reset_frame_err got %b want 1", frame_err); else passed++;
        c0 = cyc + 1;
        rand_frame();
        send_frame(L, 1'b1);
        idle(c0 + L + 3 - cyc);     // now X[2] is on op
        checks++; if (op_valid !== 1'b1) $display("FAIL pre_reset_valid got %b want 1", op_valid); else passed++;
        reset = 1'b0;
        #1;
        checks++; if (op_valid !== 1'b0) $display("FAIL rst_mid_op_valid got %b want 0", op_valid); else passed++;
        checks++; if (start_op !== 1'b0) $display("FAIL rst_mid_start_op got %b want 0", start_op); else passed++;
        checks++; if (op !== '0) $display("FAIL rst_mid_op got %h want 0", op); else passed++;
        checks++; if (frame_err !== 1'b0) $display("FAIL rst_mid_frame_err got %b want 0", frame_err); else passed++;
        for (int c = cyc; c < cyc + L; c++) begin
            ev[c] = 1'b0;
            es[c] = 1'b0;
        end
        idle(3);
        reset = 1'b1;
        idle(2 * L);
        rand_frame();
        send_frame(L, 1'b1);
        idle(L + 4);
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (lv[c] !== ev[c] || ls[c] !== es[c] || (ev[c] && (lre[c] !== ere[c] || lim[c] !== eim[c])))
                $display("FAIL reset_readout cyc=%0d got v=%0b s=%0b op=%h_%h want v=%0b s=%0b op=%h_%h",
                         c, lv[c], ls[c], lre[c], lim[c], ev[c], es[c], ere[c], eim[c]);
            else passed++;
        end
    endtask

    task automatic test_idle_gaps();
        int c0;
        bit seen;
        logic [W-1:0] hre, him;
        c0 = cyc + 1;
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            send_frame(L, 1'b1);
            idle(5);
        end
        idle(L + 4);
        seen = 1'b0;
        hre = '0;
        him = '0;
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (lv[c] !== ev[c] || ls[c] !== es[c] || (ev[c] && (lre[c] !== ere[c] || lim[c] !== eim[c])))
                $display("FAIL idle_gaps cyc=%0d got v=%0b s=%0b op=%h_%h want v=%0b s=%0b op=%h_%h",
                         c, lv[c], ls[c], lre[c], lim[c], ev[c], es[c], ere[c], eim[c]);
            else passed++;
            if (ev[c]) begin
                seen = 1'b1;
                hre  = ere[c];
                him  = eim[c];
            end else if (seen) begin
                checks++;
                if (lre[c] !== hre || lim[c] !== him)
                    $display("FAIL idle_hold cyc=%0d got %h_%h want %h_%h", c, lre[c], lim[c], hre, him);
                else passed++;
            end
        end
    endtask

    task automatic test_bank_wrap();
        int c0;
        c0 = cyc + 1;
        for (int f = 0; f < 4; f++) begin
            rand_frame();
            send_frame(L, 1'b1);
        end
        idle(L + 4);
        for (int c = c0; c < cyc; c++) begin
            checks++;
            if (lv[c] !== ev[c] || ls[c] !== es[c] || (ev[c] && (lre[c] !== ere[c] || lim[c] !== eim[c])))
                $display("FAIL bank_wrap cyc=%0d got v=%0b s=%0b op=%h_%h want v=%0b s=%0b op=%h_%h",
                         c, lv[c], ls[c], lre[c], lim[c], ev[c], es[c], ere[c], eim[c]);
            else passed++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        start_ip = 1'b0;
        ip       = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_abort();
        test_reset_readout();
        test_idle_gaps();
        test_bank_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
